// File: rtl/dice_roller_bcd.sv
// Dice-roller core: synchronises and debounces seven die buttons, runs a BCD
// counter confined to the selected die's range while held, freezes on release.
module dice_roller_bcd #(
    parameter int DIGITS       = 3,
    parameter int DEB_CYCLES   = 4,
    parameter int CUSTOM_FACES = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [6:0]          btn,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                rolling,
    output logic                result_valid,
    output logic [2:0]          die_sel
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    // Ripple BCD increment: a digit at 9 wraps to 0 and carries upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    localparam logic [W-1:0] BCD_ONE     = to_bcd(1);
    localparam logic [W-1:0] FACE_D4     = to_bcd(4);
    localparam logic [W-1:0] FACE_D6     = to_bcd(6);
    localparam logic [W-1:0] FACE_D8     = to_bcd(8);
    localparam logic [W-1:0] FACE_D10    = to_bcd(10);
    localparam logic [W-1:0] FACE_D20    = to_bcd(20);
    localparam logic [W-1:0] FACE_D100   = to_bcd(100);
    localparam logic [W-1:0] FACE_CUSTOM = to_bcd(CUSTOM_FACES);
    localparam logic [7:0]   DEB_LAST    = 8'(DEB_CYCLES - 1);

    function automatic logic [W-1:0] face_table(input logic [2:0] die);
        logic [W-1:0] r;
        case (die)
            3'd0:    r = FACE_D4;
            3'd1:    r = FACE_D6;
            3'd2:    r = FACE_D8;
            3'd3:    r = FACE_D10;
            3'd4:    r = FACE_D20;
            3'd5:    r = FACE_D100;
            default: r = FACE_CUSTOM;
        endcase
        return r;
    endfunction

    // Input conditioning keeps running regardless of ena.
    logic [6:0] sync1, sync2, deb;
    logic [7:0] deb_cnt [7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 7; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < 7; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    typedef enum logic [1:0] {IDLE, ROLL, SHOW} state_t;

    state_t       state, state_nx;
    logic [W-1:0] value, value_nx;
    logic [W-1:0] faces, faces_nx;
    logic [2:0]   die, die_nx;
    logic         valid_nx;
    logic         rolling_q, valid_q;

    always_comb begin
        state_nx = state;
        value_nx = value;
        faces_nx = faces;
        die_nx   = die;
        valid_nx = 1'b0;
        if (ena) begin
            case (state)
                IDLE, SHOW: begin
                    if (|deb) begin
                        die_nx   = lowest_set(deb);
                        faces_nx = face_table(die_nx);
                        value_nx = BCD_ONE;
                        state_nx = ROLL;
                    end
                end
                ROLL: begin
                    // Only the latched die's button matters while rolling.
                    if (!deb[die]) begin
                        state_nx = SHOW;
                        valid_nx = 1'b1;
                    end else if (value == faces) begin
                        value_nx = BCD_ONE;
                    end else begin
                        value_nx = bcd_inc(value);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            value     <= '0;
            faces     <= '0;
            die       <= '0;
            rolling_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            value     <= value_nx;
            faces     <= faces_nx;
            die       <= die_nx;
            rolling_q <= (state_nx == ROLL);
            valid_q   <= valid_nx;
        end
    end

    assign bcd_out      = value;
    assign rolling      = rolling_q;
    assign result_valid = valid_q;
    assign die_sel      = die;

endmodule

// File: tb/tb_dice_roller_bcd.sv
// Bench for dice_roller_bcd: integer reference model of the roller checked
// every cycle, plus directed scenarios and a randomized button/enable phase.
module tb_dice_roller_bcd;

    localparam int DIGITS       = 3;
    localparam int DEB_CYCLES   = 4;
    localparam int CUSTOM_FACES = 12;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [6:0]  btn;
    logic [11:0] bcd_out;
    logic        rolling;
    logic        result_valid;
    logic [2:0]  die_sel;

    int n_checks = 0;
    int n_errors = 0;

    dice_roller_bcd #(
        .DIGITS(DIGITS), .DEB_CYCLES(DEB_CYCLES), .CUSTOM_FACES(CUSTOM_FACES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn),
        .bcd_out(bcd_out), .rolling(rolling),
        .result_valid(result_valid), .die_sel(die_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) % 10 * 256 + (v / 10) % 10 * 16 + v % 10);
    endfunction

    // Reference model: integer value, pin history through two stages and a
    // run-length debounce count per button.
    int face_tab [7] = '{4, 6, 8, 10, 20, 100, CUSTOM_FACES};
    int m_sync1 [7];
    int m_sync2 [7];
    int m_deb   [7];
    int m_cnt   [7];
    int m_value, m_faces, m_die, m_low;
    bit m_roll, m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 7; i++) begin
                m_sync1[i] = 0; m_sync2[i] = 0; m_deb[i] = 0; m_cnt[i] = 0;
            end
            m_value = 0; m_faces = 0; m_die = 0; m_roll = 0; m_valid = 0;
        end else begin
            m_valid = 0;
            if (ena) begin
                if (!m_roll) begin
                    m_low = -1;
                    for (int i = 6; i >= 0; i--) if (m_deb[i] != 0) m_low = i;
                    if (m_low >= 0) begin
                        m_die = m_low; m_faces = face_tab[m_low]; m_value = 1; m_roll = 1;
                    end
                end else if (m_deb[m_die] == 0) begin
                    m_roll = 0; m_valid = 1;
                end else begin
                    m_value = (m_value == m_faces) ? 1 : m_value + 1;
                end
            end
            for (int i = 0; i < 7; i++) begin
                if (m_sync2[i] != m_deb[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB_CYCLES) begin
                        m_deb[i] = 1 - m_deb[i];
                        m_cnt[i] = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
                m_sync2[i] = m_sync1[i];
                m_sync1[i] = int'(btn[i]);
            end
        end
    end

    logic [11:0] prev_bcd = '0;
    bit seen_9_10, seen_99_100, seen_100_1;
    int valid_cnt = 0;

    always @(negedge clk) begin
        check("bcd_out", 32'(bcd_out), 32'(to_bcd(m_value)));
        check("rolling", 32'(rolling), 32'(m_roll));
        check("result_valid", 32'(result_valid), 32'(m_valid));
        check("die_sel", 32'(die_sel), 32'(m_die));
        if (rolling && prev_bcd == 12'h009 && bcd_out == 12'h010) seen_9_10 = 1;
        if (rolling && prev_bcd == 12'h099 && bcd_out == 12'h100) seen_99_100 = 1;
        if (rolling && prev_bcd == 12'h100 && bcd_out == 12'h001) seen_100_1 = 1;
        if (result_valid) valid_cnt++;
        prev_bcd = bcd_out;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        #2 rst_n = 1'b0;
        @(negedge clk);
        cycles(n);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        btn   = '0;

        // Reset holds everything at zero even with buttons toggling.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn = 7'($urandom_range(0, 127));
            check("t1_bcd", 32'(bcd_out), 32'h0);
            check("t1_roll", 32'(rolling), 32'h0);
            check("t1_die", 32'(die_sel), 32'h0);
        end
        btn = '0;
        #2 rst_n = 1'b1;
        cycles(10);

        // d4: rise latency, wrap at 4, single valid pulse on release.
        btn = 7'b0000001;
        cycles(6);
        check("t2_not_yet", 32'(rolling), 32'h0);
        cycles(1);
        check("t2_rise", 32'(rolling), 32'h1);
        check("t2_first", 32'(bcd_out), 32'h001);
        cycles(9);
        btn = '0;
        valid_cnt = 0;
        cycles(12);
        check("t2_one_pulse", 32'(valid_cnt), 32'h1);
        check("t2_frozen", 32'(bcd_out), 32'h004);
        check("t2_stopped", 32'(rolling), 32'h0);

        // d100: long hold crosses digit carries and wraps to 1.
        btn = 7'b0100000;
        cycles(240);
        btn = '0;
        cycles(12);
        check("t3_9_to_10", 32'(seen_9_10), 32'h1);
        check("t3_99_to_100", 32'(seen_99_100), 32'h1);
        check("t3_100_to_1", 32'(seen_100_1), 32'h1);

        // d8: short glitch ignored, slightly longer pulse accepted.
        btn = 7'b0000100;
        cycles(DEB_CYCLES - 1);
        btn = '0;
        cycles(12);
        check("t4_glitch", 32'(rolling), 32'h0);
        btn = 7'b0000100;
        cycles(DEB_CYCLES + 2);
        btn = '0;
        cycles(2);
        check("t4_roll", 32'(rolling), 32'h1);
        check("t4_die", 32'(die_sel), 32'h2);
        cycles(12);

        // d6 + d20: lowest wins, d20 activity ignored, d20 re-rolls after.
        btn = 7'b0010010;
        cycles(8);
        check("t5_die", 32'(die_sel), 32'h1);
        cycles(10);
        btn = 7'b0000010;
        cycles(8);
        btn = 7'b0010010;
        cycles(8);
        check("t5_still_d6", 32'(die_sel), 32'h1);
        btn = 7'b0010000;
        cycles(7);
        check("t5_valid", 32'(result_valid), 32'h1);
        cycles(1);
        check("t5_reroll", 32'(rolling), 32'h1);
        check("t5_die20", 32'(die_sel), 32'h4);
        check("t5_restart", 32'(bcd_out), 32'h001);
        btn = '0;
        cycles(12);

        // Custom die: ena freeze, release while frozen, then reset mid-roll.
        btn = 7'b1000000;
        cycles(20);
        ena = 1'b0;
        btn = '0;
        cycles(12);
        check("t6_frozen_roll", 32'(rolling), 32'h1);
        ena = 1'b1;
        cycles(1);
        check("t6_valid", 32'(result_valid), 32'h1);
        btn = 7'b1000000;
        cycles(12);
        valid_cnt = 0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_bcd", 32'(bcd_out), 32'h0);
        check("t6_async_roll", 32'(rolling), 32'h0);
        @(negedge clk);
        btn = '0;
        cycles(2);
        #2 rst_n = 1'b1;
        cycles(3);
        check("t6_no_pulse", 32'(valid_cnt), 32'h0);

        // Random phase: random button sets, hold lengths, enable and resets.
        for (int s = 0; s < 120; s++) begin
            if ($urandom_range(0, 3) != 0) btn = 7'(1 << $urandom_range(0, 6));
            else btn = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 5) == 0) btn = '0;
            ena = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 30) == 0) pulse_reset($urandom_range(1, 3));
            cycles($urandom_range(1, 14));
        end
        ena = 1'b1;
        btn = '0;
        cycles(15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
